// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave, MSB first, with every SPI pin oversampled in the system clock domain.
// Received words come out as a one-cycle strobe; transmit words are offered on a valid/ready port.
module spi_slave_responder #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_ss_n,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] WordBits = CntW'(DATA_W);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e                   state;
  logic [SYNC_STAGES-1:0]   sclk_sync;
  logic [SYNC_STAGES-1:0]   mosi_sync;
  logic [SYNC_STAGES-1:0]   ss_sync;
  logic                     sclk_dly;
  logic                     ss_dly;
  logic [DATA_W-1:0]        hold_q;
  logic [DATA_W-1:0]        tx_shift;
  logic [DATA_W-1:0]        rx_shift;
  logic [CntW-1:0]          bitcnt;

  logic                     sclk_s;
  logic                     mosi_s;
  logic                     ss_s;
  logic                     sclk_rise;
  logic                     sclk_fall;
  logic                     ss_fall;
  logic                     ss_rise;
  logic                     accept;
  logic                     load;
  logic [DATA_W-1:0]        load_word;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly;
  assign sclk_fall = ~sclk_s & sclk_dly;
  assign ss_fall   = ~ss_s & ss_dly;
  assign ss_rise   = ss_s & ~ss_dly;
  assign busy      = ~ss_s;

  assign accept    = tx_valid & tx_ready;
  // A word is pulled from holding on select and on every falling edge at a word boundary;
  // deselect wins over a coincident sclk edge.
  assign load      = ((state == StIdle) & ss_fall) |
                     ((state == StActive) & ~ss_rise & sclk_fall & (bitcnt == '0));
  // tx_ready doubles as the "holding empty" flag, so an empty load sends zeros.
  assign load_word = tx_ready ? '0 : hold_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= StIdle;
      sclk_sync   <= '0;
      mosi_sync   <= '0;
      ss_sync     <= '1;
      sclk_dly    <= 1'b0;
      ss_dly      <= 1'b1;
      hold_q      <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bitcnt      <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      tx_ready    <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      ss_sync     <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
      sclk_dly    <= sclk_s;
      ss_dly      <= ss_s;
      rx_valid    <= 1'b0;
      tx_underrun <= load & tx_ready;

      if (load && !tx_ready) begin
        tx_ready <= 1'b1;
      end else if (accept) begin
        hold_q   <= tx_data;
        tx_ready <= 1'b0;
      end

      unique case (state)
        StIdle: begin
          if (ss_fall) begin
            state       <= StActive;
            spi_miso_oe <= 1'b1;
            bitcnt      <= '0;
            tx_shift    <= load_word;
            spi_miso    <= load_word[DATA_W-1];
          end
        end
        StActive: begin
          if (ss_rise) begin
            state       <= StIdle;
            spi_miso_oe <= 1'b0;
            spi_miso    <= 1'b0;
            bitcnt      <= '0;
          end else begin
            // The completed word is published one cycle after the last rising edge.
            if (bitcnt == WordBits) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
              bitcnt   <= '0;
            end else if (sclk_rise) begin
              rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
              bitcnt   <= bitcnt + 1'b1;
            end
            if (sclk_fall) begin
              if (bitcnt == '0) begin
                tx_shift <= load_word;
                spi_miso <= load_word[DATA_W-1];
              end else begin
                tx_shift <= tx_shift << 1;
                spi_miso <= tx_shift[DATA_W-2];
              end
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: a bit-banged mode-0 master plus strobe counters.
module tb_spi_slave_responder;

  localparam int unsigned DW   = 8;
  localparam int unsigned SS   = 2;
  localparam int          HALF = 12;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          spi_sclk = 1'b0;
  logic          spi_mosi = 1'b0;
  logic          spi_ss_n = 1'b1;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          spi_miso;
  logic          spi_miso_oe;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          tx_underrun;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  int rx_cnt  = 0;
  int un_cnt  = 0;
  int oe_cnt  = 0;
  logic [DW-1:0] rx_log [0:63];

  always #10 clk = ~clk;

  spi_slave_responder #(
    .DATA_W      (DW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_ss_n    (spi_ss_n),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .busy        (busy)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt % 64] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (tx_underrun) un_cnt <= un_cnt + 1;
    if (spi_miso_oe) oe_cnt <= oe_cnt + 1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [DW-1:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    for (int k = 0; k < 50 && !tx_ready; k++) @(negedge clk);
    if (!tx_ready) begin
      n_fail++;
      $display("FAIL push_timeout: tx_ready=%0b want 1", tx_ready);
    end
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic spi_select();
    @(negedge clk);
    spi_ss_n = 1'b0;
    wait_clks(HALF);
  endtask

  // Mode-0 master: MISO sampled at each rising edge; last=1 releases ss_n with the final fall.
  task automatic spi_bits(input logic [DW-1:0] mo, input int nbits, input bit last,
                          output logic [DW-1:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[DW-1-i];
      @(negedge clk);
      mi[DW-1-i] = spi_miso;
      spi_sclk = 1'b1;
      wait_clks(HALF);
      spi_sclk = 1'b0;
      if (last && i == nbits - 1) spi_ss_n = 1'b1;
      wait_clks(HALF - 1);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wait_clks(3);
    n_tests++;
    if ({spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy} !==
        {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got miso=%0b oe=%0b rdy=%0b rx=%0h rxv=%0b un=%0b busy=%0b want 0 0 1 00 0 0 0",
               spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy);
    end
    reset_n = 1'b1;
    wait_clks(2);
  endtask

  task automatic test_basic();
    logic [DW-1:0] mi;
    int r0, u0;
    r0 = rx_cnt; u0 = un_cnt;
    push(8'hA5);
    n_tests++;
    if (tx_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_ready_after_accept: got %0b want 0", tx_ready);
    end
    spi_select();
    n_tests++;
    if ({spi_miso_oe, busy, tx_ready} !== 3'b111) begin
      n_fail++; $display("FAIL basic_select: got oe/busy/rdy=%b want 111", {spi_miso_oe, busy, tx_ready});
    end
    spi_bits(8'h3C, 8, 1'b1, mi);
    wait_clks(4);
    n_tests++;
    if (mi !== 8'hA5) begin n_fail++; $display("FAIL basic_miso: got %0h want a5", mi); end
    n_tests++;
    if (rx_data !== 8'h3C || rx_cnt - r0 != 1) begin
      n_fail++; $display("FAIL basic_rx: got %0h x%0d want 3c x1", rx_data, rx_cnt - r0);
    end
    n_tests++;
    if (un_cnt - u0 != 0 || spi_miso_oe !== 1'b0) begin
      n_fail++; $display("FAIL basic_underrun_oe: got un=%0d oe=%0b want 0 0", un_cnt - u0, spi_miso_oe);
    end
  endtask

  task automatic test_underrun();
    logic [DW-1:0] mi;
    int r0, u0;
    r0 = rx_cnt; u0 = un_cnt;
    spi_select();
    spi_bits(8'hFF, 8, 1'b1, mi);
    wait_clks(4);
    n_tests++;
    if (mi !== 8'h00) begin n_fail++; $display("FAIL underrun_miso: got %0h want 00", mi); end
    n_tests++;
    if (un_cnt - u0 != 1) begin
      n_fail++; $display("FAIL underrun_count: got %0d want 1", un_cnt - u0);
    end
    n_tests++;
    if (rx_data !== 8'hFF || rx_cnt - r0 != 1) begin
      n_fail++; $display("FAIL underrun_rx: got %0h x%0d want ff x1", rx_data, rx_cnt - r0);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] mi1, mi2;
    int r0, u0;
    r0 = rx_cnt; u0 = un_cnt;
    push(8'h11);
    spi_select();
    push(8'h22);
    n_tests++;
    if (tx_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ready_held: got %0b want 0", tx_ready);
    end
    spi_bits(8'hA1, 8, 1'b0, mi1);
    spi_bits(8'h5E, 8, 1'b1, mi2);
    wait_clks(4);
    n_tests++;
    if ({mi1, mi2} !== 16'h1122) begin
      n_fail++; $display("FAIL b2b_miso: got %0h %0h want 11 22", mi1, mi2);
    end
    n_tests++;
    if (rx_cnt - r0 != 2 || rx_log[r0 % 64] !== 8'hA1 || rx_log[(r0 + 1) % 64] !== 8'h5E) begin
      n_fail++; $display("FAIL b2b_rx: got x%0d %0h %0h want x2 a1 5e", rx_cnt - r0,
                         rx_log[r0 % 64], rx_log[(r0 + 1) % 64]);
    end
    n_tests++;
    if (tx_ready !== 1'b1 || un_cnt - u0 != 0) begin
      n_fail++; $display("FAIL b2b_drain: got rdy=%0b un=%0d want 1 0", tx_ready, un_cnt - u0);
    end
  endtask

  task automatic test_abort();
    logic [DW-1:0] mi;
    int r0;
    push(8'hC3);
    r0 = rx_cnt;
    spi_select();
    spi_bits(8'hA8, 5, 1'b0, mi);
    n_tests++;
    if (spi_miso_oe !== 1'b1) begin n_fail++; $display("FAIL abort_oe_before: got 0 want 1"); end
    @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (SS + 1) @(posedge clk);
    #1;
    n_tests++;
    if ({spi_miso_oe, spi_miso} !== 2'b00) begin
      n_fail++; $display("FAIL abort_release: got oe/miso=%b want 00", {spi_miso_oe, spi_miso});
    end
    wait_clks(HALF);
    n_tests++;
    if (rx_cnt - r0 != 0 || rx_data !== 8'h5E || mi[7:3] !== 5'b11000) begin
      n_fail++; $display("FAIL abort_partial: got x%0d rx=%0h bits=%b want x0 5e 11000",
                         rx_cnt - r0, rx_data, mi[7:3]);
    end
    push(8'h96);
    r0 = rx_cnt;
    spi_select();
    spi_bits(8'h81, 8, 1'b1, mi);
    wait_clks(4);
    n_tests++;
    if (mi !== 8'h96 || rx_data !== 8'h81 || rx_cnt - r0 != 1) begin
      n_fail++; $display("FAIL abort_next: got miso=%0h rx=%0h x%0d want 96 81 x1", mi, rx_data, rx_cnt - r0);
    end
  endtask

  task automatic test_latency();
    int r0;
    push(8'h40);
    r0 = rx_cnt;
    spi_select();
    for (int i = 0; i < 8; i++) begin
      spi_mosi = 1'b1;
      @(negedge clk);
      spi_sclk = 1'b1;
      if (i == 7) begin
        repeat (SS + 1) @(posedge clk);
        #1;
        n_tests++;
        if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL lat_rxv_early: got 1 want 0"); end
        @(posedge clk);
        #1;
        n_tests++;
        if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL lat_rxv_on_time: got 0 want 1"); end
      end
      wait_clks(HALF);
      spi_sclk = 1'b0;
      if (i == 7) spi_ss_n = 1'b1;
      if (i == 0) begin
        repeat (SS) @(posedge clk);
        #1;
        n_tests++;
        if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL lat_miso_early: got 1 want 0"); end
        @(posedge clk);
        #1;
        n_tests++;
        if (spi_miso !== 1'b1) begin n_fail++; $display("FAIL lat_miso_on_time: got 0 want 1"); end
      end
      wait_clks(HALF - 1);
    end
    wait_clks(4);
    n_tests++;
    if (rx_data !== 8'hFF || rx_cnt - r0 != 1) begin
      n_fail++; $display("FAIL lat_rx: got %0h x%0d want ff x1", rx_data, rx_cnt - r0);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] mi;
    int r0;
    push(8'h5A);
    spi_select();
    push(8'h77);
    spi_bits(8'hF0, 4, 1'b0, mi);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if ({spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy} !==
        {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_outputs: got miso=%0b oe=%0b rdy=%0b rx=%0h rxv=%0b un=%0b busy=%0b want 0 0 1 00 0 0 0",
               spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy);
    end
    spi_ss_n = 1'b1;
    wait_clks(3);
    reset_n = 1'b1;
    wait_clks(2);
    push(8'hE7);
    r0 = rx_cnt;
    spi_select();
    spi_bits(8'h69, 8, 1'b1, mi);
    wait_clks(4);
    n_tests++;
    if (mi !== 8'hE7 || rx_data !== 8'h69 || rx_cnt - r0 != 1) begin
      n_fail++; $display("FAIL midreset_next: got miso=%0h rx=%0h x%0d want e7 69 x1", mi, rx_data, rx_cnt - r0);
    end
  endtask

  task automatic test_ignore();
    int r0, u0, o0;
    r0 = rx_cnt; u0 = un_cnt; o0 = oe_cnt;
    spi_ss_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      spi_mosi = i[1];
      spi_sclk = i[0];
      wait_clks(6);
    end
    spi_sclk = 1'b0;
    wait_clks(4);
    n_tests++;
    if (rx_cnt - r0 != 0 || un_cnt - u0 != 0 || oe_cnt - o0 != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ignore_idle: got rxv=%0d un=%0d oe=%0d busy=%0b want 0 0 0 0",
                         rx_cnt - r0, un_cnt - u0, oe_cnt - o0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_back_to_back();
    test_abort();
    test_latency();
    test_reset_mid();
    test_ignore();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
